// File: rtl/vga_test_core.sv
// 640x480@60 VGA test-pattern generator: shows the switch colour across the whole active area.
// Pixel rate is a 1-in-CLK_DIV enable on clk. Sync and colour outputs are registered together.
module vga_test_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sw,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [11:0]      sw_s1_q, sw_s2_q;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             pixel_tick;
  logic             end_of_line;
  logic             video_on;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    div_d       = div_q + DIV_W'(1);
    h_d         = h_q;
    v_d         = v_q;
    pixel_tick  = (div_q == DIV_LAST);
    end_of_line = pixel_tick && (h_q == H_LAST);

    if (pixel_tick) begin
      div_d = '0;
      h_d   = end_of_line ? 10'd0 : h_q + 10'd1;
    end
    if (end_of_line) begin
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end

    // Decode uses the current counters; the output register adds the single clk of latency.
    video_on = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_d  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vsync_d  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    rgb_d    = video_on ? sw_s2_q : 12'h000;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_vga_test_core.sv
// Bench for vga_test_core: a full-size instance for line timing and switch tracking,
// and a shrunken-timing instance so whole frames fit in a short run.
module tb_vga_test_core;

  typedef struct {
    logic [11:0] sw;
    int          clks;
    logic [13:0] exp;   // {hsync, vsync, rgb}
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sw_a, sw_b;
  logic        hs_a, vs_a, hs_b, vs_b;
  logic [11:0] rgb_a, rgb_b;
  int          k;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[15];

  vga_test_core dut_a (
    .clk(clk), .reset(reset), .sw(sw_a),
    .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a)
  );

  // Small timing: line = 32 pixels (128 clks), frame = 12 lines (1536 clks).
  // hsync low for h 20..27, vsync low for v 8..9, active h<16, v<6.
  vga_test_core #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(4)
  ) dut_b (
    .clk(clk), .reset(reset), .sw(sw_b),
    .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b)
  );

  always #5 clk = ~clk;

  // k = number of rising edges since reset release; outputs sampled after edge k
  // reflect h = (k-1)/CLK_DIV, so the expected values below follow from that.
  always @(posedge clk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hs=%b vs=%b rgb=%h, expected hs=%b vs=%b rgb=%h",
               name, act[13], act[12], act[11:0], exp[13], exp[12], exp[11:0]);
    end
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 100000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (k != target) begin
      n_err++;
      $display("FAIL goto: reached cycle %0d, wanted %0d", k, target);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] s, input int c, input logic [11:0] e, input string n);
    vec_t v;
    v.sw = s; v.clks = c; v.exp = {2'b11, e}; v.name = n;
    return v;
  endfunction

  initial begin
    logic [11:0] colours[5];
    logic [11:0] prev;

    colours = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h000};
    prev = 12'h000;
    for (int i = 0; i < 5; i++) begin
      tbl[3*i]   = mk(colours[i], 2,  prev,       $sformatf("sw%h_before", colours[i]));
      tbl[3*i+1] = mk(colours[i], 1,  colours[i], $sformatf("sw%h_3clk",   colours[i]));
      tbl[3*i+2] = mk(colours[i], 17, colours[i], $sformatf("sw%h_hold",   colours[i]));
      prev = colours[i];
    end

    // Reset held for 100 ns.
    reset = 1'b0;
    sw_a  = 12'h000;
    sw_b  = 12'h000;
    repeat (5) @(posedge clk);
    #1 check("reset_a_50ns", {hs_a, vs_a, rgb_a}, 14'h3000);
    repeat (5) @(posedge clk);
    #1 check("reset_a_100ns", {hs_a, vs_a, rgb_a}, 14'h3000);
    check("reset_b_100ns", {hs_b, vs_b, rgb_b}, 14'h3000);

    @(negedge clk) reset = 1'b1;

    // Switch tracking in the first active line.
    goto(20);
    for (int i = 0; i < 15; i++) begin
      sw_a = tbl[i].sw;
      repeat (tbl[i].clks) @(posedge clk);
      #1 check(tbl[i].name, {hs_a, vs_a, rgb_a}, tbl[i].exp);
    end

    // Line timing: blank at h=640, hsync low h=656..751, period 3200 clks.
    sw_a = 12'hFFF;
    goto(2560); check("last_active_px",  {hs_a, vs_a, rgb_a}, {2'b11, 12'hFFF});
    goto(2561); check("hblank_start",    {hs_a, vs_a, rgb_a}, {2'b11, 12'h000});
    goto(2624); check("hsync_pre_fall",  {hs_a, vs_a, rgb_a}, {2'b11, 12'h000});
    goto(2625); check("hsync_fall",      {hs_a, vs_a, rgb_a}, {2'b01, 12'h000});
    goto(2700); sw_a = 12'h5A3;
    goto(2800); check("hblank_sw_toggle", {hs_a, vs_a, rgb_a}, {2'b01, 12'h000});
    goto(3008); check("hsync_last_low",  {hs_a, vs_a, rgb_a}, {2'b01, 12'h000});
    goto(3009); check("hsync_rise",      {hs_a, vs_a, rgb_a}, {2'b11, 12'h000});
    goto(3200); check("h799_blank",      {hs_a, vs_a, rgb_a}, {2'b11, 12'h000});
    goto(3201); check("h_wrap_new_sw",   {hs_a, vs_a, rgb_a}, {2'b11, 12'h5A3});
    goto(5824); check("hsync2_pre_fall", {hs_a, vs_a, rgb_a}, {2'b11, 12'h000});
    goto(5825); check("hsync2_fall",     {hs_a, vs_a, rgb_a}, {2'b01, 12'h000});

    // Asynchronous reset between clock edges during hsync.
    goto(5830); check("pre_async_rst",   {hs_a, vs_a, rgb_a}, {2'b01, 12'h000});
    #2 reset = 1'b0;
    #1 check("async_rst_a",  {hs_a, vs_a, rgb_a}, 14'h3000);
    check("async_rst_b",     {hs_b, vs_b, rgb_b}, 14'h3000);

    // Small-timing instance: frame-level behaviour.
    repeat (5) @(posedge clk);
    sw_b = 12'hFFF;
    @(negedge clk) reset = 1'b1;

    goto(2);    check("b_sync_lat_2",   {hs_b, vs_b, rgb_b}, {2'b11, 12'h000});
    goto(3);    check("b_sync_lat_3",   {hs_b, vs_b, rgb_b}, {2'b11, 12'hFFF});
    goto(80);   check("b_hblank",       {hs_b, vs_b, rgb_b}, {2'b11, 12'h000});
    goto(81);   check("b_hsync_fall",   {hs_b, vs_b, rgb_b}, {2'b01, 12'h000});
    goto(700);  check("b_last_act_line",{hs_b, vs_b, rgb_b}, {2'b11, 12'hFFF});
    goto(800);  check("b_vblank_rgb0",  {hs_b, vs_b, rgb_b}, {2'b11, 12'h000});
    goto(1024); check("b_vsync_pre",    {hs_b, vs_b, rgb_b}, {2'b11, 12'h000});
    goto(1025); check("b_vsync_fall",   {hs_b, vs_b, rgb_b}, {2'b10, 12'h000});
    goto(1280); check("b_vsync_last",   {hs_b, vs_b, rgb_b}, {2'b10, 12'h000});
    goto(1281); check("b_vsync_rise",   {hs_b, vs_b, rgb_b}, {2'b11, 12'h000});
    goto(1536); check("b_h31_v11",      {hs_b, vs_b, rgb_b}, {2'b11, 12'h000});
    goto(1537); check("b_frame_wrap",   {hs_b, vs_b, rgb_b}, {2'b11, 12'hFFF});
    goto(2560); check("b_vsync2_pre",   {hs_b, vs_b, rgb_b}, {2'b11, 12'h000});
    goto(2561); check("b_vsync2_fall",  {hs_b, vs_b, rgb_b}, {2'b10, 12'h000});
    goto(3076); check("b_frame3_active",{hs_b, vs_b, rgb_b}, {2'b11, 12'hFFF});

    // Asynchronous reset while showing colour.
    #2 reset = 1'b0;
    #1 check("b_async_rst_active", {hs_b, vs_b, rgb_b}, 14'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_test_core.md
Name:
vga_test_core

Overview:
- 640x480 @ 60 Hz VGA test-pattern generator for the Basys-3 board, driven by the 100 MHz board clock.
- Generates hsync and vsync.
- Drives the 12-bit RGB output with the colour set on the 12 slide switches during the active video area, and black during blanking.
- Used as a bring-up block to check the VGA path before the Sobel datapath is attached.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel (100 MHz to 25 MHz)

Ports:
- clk  input  1  100 MHz system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- sw  input  12  colour select {R[11:8], G[7:4], B[3:0]}; asynchronous to clk
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- rgb  output  12  pixel colour {R, G, B}

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low. While reset=0: divider=0, h_count=0, v_count=0, sw synchroniser=0, hsync=1, vsync=1, rgb=0x000.
- Pixel tick:
  - 2-bit divider counts 0..CLK_DIV-1 every clk.
  - pixel_tick=1 for one clk when divider==CLK_DIV-1, so one tick per 4 clks (25 MHz enable, not a derived clock).
- Horizontal counter:
  - h_count (10 bits), 0..H_TOTAL-1, where H_TOTAL=800; advances only on pixel_tick.
  - At 799 with a tick it wraps to 0 and generates end_of_line.
- Vertical counter:
  - v_count (10 bits), 0..V_TOTAL-1, where V_TOTAL=525; advances only on a tick where end_of_line is true.
  - It wraps 524 to 0 on end of the last line.
- Sync decode:
  - hsync_next = 0 iff 656 <= h_count <= 751, else 1.
  - vsync_next = 0 iff 490 <= v_count <= 491, else 1.
- Active video: video_on = (h_count < 640) && (v_count < 480).
- Switch synchroniser: sw passes through a 2-flop synchroniser (sw_s1, sw_s2) clocked every clk.
- Output registers:
  - hsync, vsync and rgb are registered every clk from the current counter values, giving 1 clk of latency; all three outputs stay mutually aligned.
  - rgb <= video_on ? sw_s2 : 12'h000.
  - Latency from a sw change to rgb is 3 clks (30 ns) while in the active area.
- sw changes mid-line take effect immediately; there is no frame or line latching.
- Timing results:
  - Line period 3200 clks (32 us); hsync low 384 clks.
  - Frame period 1,680,000 clks (16.8 ms); vsync low 2 lines (6400 clks).
  - First hsync falling edge occurs 2624 clks after the first post-reset tick alignment (h_count reaches 656), plus the 1-clk output register.
- Reset mid-frame returns all state to its reset values immediately (asynchronously). After release, timing restarts from h=0, v=0, which is the active area, so rgb follows sw from the first line.
- No blanking glitch: rgb is exactly 0 whenever h_count >= 640 or v_count >= 480.

Test Plan:
- Hold reset=0 for 100 ns with sw=0x000 -> hsync=1, vsync=1, rgb=0x000 throughout; asserting reset=0 mid-line forces the same values without waiting for a clk edge.
- Release reset, then set sw=0xFFF at t=200 ns -> rgb=0xFFF within 3 clks. Then step sw through 0xF00, 0x0F0, 0x00F, 0x000 at 200 ns intervals -> rgb tracks each value 3 clks after the change.
- Run one full line -> rgb drops to 0x000 when h_count reaches 640. hsync goes low at h_count 656 for exactly 384 clks, and the hsync period is 3200 clks.
- Run 2 full frames -> vsync is low for 6400 clks with a 1,680,000-clk period. rgb=0x000 during vertical blanking (v_count 480..524) regardless of sw=0xFFF.
- Counter wrap: at h=799, v=524 with a tick -> both counters go to 0, and rgb resumes sw on the next output register update.
- Toggle sw during horizontal blanking -> rgb stays 0x000 until h_count wraps to 0, then shows the new sw value.
